// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM condition evaluation, NZCV register and one-entry decision stage.
// Optional direct flag write port enabled by defining CPSR_WRITE_EN.
module cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic        s_bit,
  input  logic        logic_op,
  input  logic [3:0]  alu_flags,
  input  logic        shifter_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        exec,
  output logic [3:0]  flags_q,
  output logic        carry_to_alu,
  output logic [15:0] annul_count
`ifdef CPSR_WRITE_EN
  ,
  input  logic        flag_wr,
  input  logic [3:0]  flag_wdata
`endif
);

  logic n, z, c, v;
  logic pass;
  logic accept;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign carry_to_alu = flags_q[1];

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'd0:  pass = z;
      4'd1:  pass = !z;
      4'd2:  pass = c;
      4'd3:  pass = !c;
      4'd4:  pass = n;
      4'd5:  pass = !n;
      4'd6:  pass = v;
      4'd7:  pass = !v;
      4'd8:  pass = c && !z;
      4'd9:  pass = !c || z;
      4'd10: pass = (n == v);
      4'd11: pass = (n != v);
      4'd12: pass = !z && (n == v);
      4'd13: pass = z || (n != v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      exec        <= 1'b0;
      flags_q     <= 4'b0000;
      annul_count <= 16'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        exec      <= pass;
        if (!pass && annul_count != 16'hFFFF)
          annul_count <= annul_count + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Direct write wins over an S-update landing on the same edge.
`ifdef CPSR_WRITE_EN
      if (flag_wr)
        flags_q <= flag_wdata;
      else
`endif
      if (accept && pass && s_bit)
        flags_q <= logic_op ? {alu_flags[3:2], shifter_carry, flags_q[0]} : alu_flags;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit against a behavioural model.
module tb_cond_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = 4'd0;
  logic        s_bit = 1'b0;
  logic        logic_op = 1'b0;
  logic [3:0]  alu_flags = 4'd0;
  logic        shifter_carry = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        exec;
  logic [3:0]  flags_q;
  logic        carry_to_alu;
  logic [15:0] annul_count;
`ifdef CPSR_WRITE_EN
  logic        flag_wr = 1'b0;
  logic [3:0]  flag_wdata = 4'd0;
`endif

  int checks = 0;
  int failures = 0;

  // Model state
  logic        m_ov, m_exec;
  logic [3:0]  m_flags;
  int          m_annul;

  always #5 clk = ~clk;

  cond_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .s_bit(s_bit), .logic_op(logic_op), .alu_flags(alu_flags),
    .shifter_carry(shifter_carry), .out_valid(out_valid), .out_ready(out_ready),
    .exec(exec), .flags_q(flags_q), .carry_to_alu(carry_to_alu),
    .annul_count(annul_count)
`ifdef CPSR_WRITE_EN
    , .flag_wr(flag_wr), .flag_wdata(flag_wdata)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Conditions come in complementary pairs: even code tests a base predicate, odd inverts it.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv, b;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (c[3:1])
      3'd0: b = fz;
      3'd1: b = fc;
      3'd2: b = fn;
      3'd3: b = fv;
      3'd4: b = fc & !fz;
      3'd5: b = (fn == fv);
      3'd6: b = !fz & (fn == fv);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ov = 0; m_exec = 0; m_flags = 4'd0; m_annul = 0;
    end else begin
      logic acc, p;
      logic [3:0] nf;
      acc = in_valid && (!m_ov || out_ready);
      p = model_pass(cond, m_flags);
      nf = m_flags;
      if (acc) begin
        m_ov = 1; m_exec = p;
        if (!p && m_annul < 65535) m_annul = m_annul + 1;
        if (p && s_bit) nf = logic_op ? {alu_flags[3], alu_flags[2], shifter_carry, m_flags[0]} : alu_flags;
      end else if (out_ready) begin
        m_ov = 0;
      end
`ifdef CPSR_WRITE_EN
      if (flag_wr) nf = flag_wdata;
`endif
      m_flags = nf;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_out_valid", out_valid, m_ov);
      if (m_ov) chk("cmp_exec", exec, m_exec);
      chk("cmp_flags", flags_q, m_flags);
      chk("cmp_carry", carry_to_alu, m_flags[1]);
      chk("cmp_annul", annul_count, m_annul);
      chk("cmp_in_ready", in_ready, !m_ov || out_ready);
    end
  end

  task automatic cyc(input logic iv, input logic [3:0] c, input logic s, input logic lo,
                     input logic [3:0] af, input logic sc, input logic ordy);
    in_valid = iv; cond = c; s_bit = s; logic_op = lo; alu_flags = af;
    shifter_carry = sc; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exec", exec, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_carry", carry_to_alu, 0);
    chk("rst_annul", annul_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); #2; reset = 0;

    cyc(1, 4'd14, 1, 0, 4'b0100, 0, 1);
    chk("al_out_valid", out_valid, 1);
    chk("al_exec", exec, 1);
    chk("al_flags", flags_q, 4'b0100);

    cyc(1, 4'd1, 1, 0, 4'b1000, 0, 1);
    chk("ne_exec", exec, 0);
    chk("ne_flags", flags_q, 4'b0100);
    chk("ne_annul", annul_count, 1);

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        cyc(1, 4'd14, 1, 0, f[3:0], 0, 1);
        cyc(1, c[3:0], 0, 0, 4'd0, 0, 1);
        if (c == 15) chk("nv_exec", exec, 0);
      end
    end
    // Hand-computed: flags 1001 (N=1,V=1) -> GE passes, GT passes (Z=0), LT fails.
    cyc(1, 4'd14, 1, 0, 4'b1001, 0, 1);
    cyc(1, 4'd10, 0, 0, 4'd0, 0, 1);
    chk("ge_exec", exec, 1);
    cyc(1, 4'd11, 0, 0, 4'd0, 0, 1);
    chk("lt_exec", exec, 0);

    cyc(1, 4'd14, 1, 0, 4'b0011, 0, 1);
    cyc(1, 4'd14, 1, 1, 4'b1000, 0, 1);
    chk("logic_flags", flags_q, 4'b1001);

    // Stall: pending decision held, nothing accepted, flags untouched.
    cyc(1, 4'd14, 0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'd15, 1, 0, 4'b1111, 0, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_flags", flags_q, 4'b1001);
      chk("stall_exec", exec, 1);
    end
    for (int i = 0; i < 4; i++) cyc(1, i[3:0], 0, 0, 4'd0, 0, 1);
    cyc(0, 4'd0, 0, 0, 4'd0, 0, 1);
    chk("drain_out_valid", out_valid, 0);

    // Reset mid-transfer.
    cyc(1, 4'd14, 1, 0, 4'b1110, 1, 0);
    reset = 1; #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flags", flags_q, 0);
    chk("midrst_annul", annul_count, 0);
    @(negedge clk); #2; reset = 0;
    cyc(1, 4'd0, 1, 0, 4'b0000, 0, 1);
    chk("post_rst_exec", exec, 0);

`ifdef CPSR_WRITE_EN
    flag_wr = 1; flag_wdata = 4'b0010;
    cyc(1, 4'd14, 1, 0, 4'b1111, 0, 1);
    flag_wr = 0;
    chk("wr_flags", flags_q, 4'b0010);
    chk("wr_carry", carry_to_alu, 1);
`endif

    cyc(0, 4'd0, 0, 0, 4'd0, 0, 1);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-evaluation and status-register block that sits downstream of the ALU and consumes its 4-bit flag output. It holds the architectural NZCV register, evaluates each instruction's 4-bit ARM condition field against it, and commits new flags when the instruction passes and has its S bit set. It returns the stored carry to the ALU `carry` input for ADC/SBC/RSC. Instructions flow through a one-entry valid/ready pipeline stage.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage can accept this cycle.
- cond  in  4  ARM condition field.
- s_bit  in  1  instruction updates flags.
- logic_op  in  1  ALU op is logical (AND/EOR/TST/TEQ/ORR/BIC/PAS/MVN).
- alu_flags  in  4  ALU flags {N,Z,C,V}: [3]=`NEG, [2]=`ZER, [1]=`CAR, [0]=`OVR.
- shifter_carry  in  1  barrel-shifter carry-out, used as C for logical ops.
- out_valid  out  1  registered decision available.
- out_ready  in  1  downstream accepts decision.
- exec  out  1  registered condition result (1 = execute).
- flags_q  out  4  architectural NZCV, same bit order as alu_flags.
- carry_to_alu  out  1  equals flags_q[1].
- annul_count  out  16  saturating count of instructions whose condition failed.
- flag_wr, flag_wdata  in  1, 4  direct flag write (only with CPSR_WRITE_EN).

## Operation
- Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (combinational).
- Condition truth on accept, using current flags_q: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- On accept: exec <= pass; out_valid <= 1.
- Flag commit on accept if pass & s_bit:
  - arithmetic op: flags_q <= alu_flags.
  - logic_op: N,Z from alu_flags; C <= shifter_carry; V unchanged.
- On accept with !pass: annul_count += 1, saturating at 0xFFFF.
- Output held stable while out_valid & !out_ready.
- out_valid clears when out_ready & !in_valid-accept in the same cycle.
- No flag forwarding: each accepted instruction sees flags committed by all earlier accepts (registered update completes before the next accept).

## Timing
- Reset values: out_valid 0, exec 0, flags_q 4'b0000, carry_to_alu 0, annul_count 0; in_ready 1 after reset.
- Reset asserted mid-transfer: pending decision dropped, flags cleared, no completion.
- Latency: accept at edge N produces out_valid/exec valid after edge N; flags_q updated at the same edge N.
- Throughput: one instruction per cycle when out_ready held high.
- Back-to-back accepts: second instruction evaluates against flags written by the first.
- Stall: out_ready low with out_valid high -> in_ready low, flags_q and annul_count frozen.

## Configuration
- CPSR_WRITE_EN defined: flag_wr/flag_wdata ports exist. flag_wr=1 loads flags_q <= flag_wdata at the clock edge, independent of handshake. flag_wr has priority over an S-update in the same cycle.
- CPSR_WRITE_EN undefined: ports absent; flags change only through S-updates and reset.

## Test plan
- Reset, then accept cond=14 (AL), s_bit=1, alu_flags=4'b0100 -> next cycle out_valid=1, exec=1, flags_q=4'b0100.
- With flags_q=4'b0100, accept cond=1 (NE), s_bit=1, alu_flags=4'b1000 -> exec=0, flags_q stays 4'b0100, annul_count=1.
- Sweep all 16 conds across all 16 flag values -> exec matches the table; NV is always 0.
- With flags_q=4'b0011, logic_op=1, s_bit=1, alu_flags=4'b1000, shifter_carry=0 -> flags_q=4'b1001 (V preserved).
- Hold out_ready=0 with out_valid=1 and in_valid=1 for 3 cycles -> in_ready=0, outputs and flags frozen. Release -> one decision per cycle.
- CPSR_WRITE_EN: flag_wr=1, flag_wdata=4'b0010, together with an accepted S-update of 4'b1111 -> flags_q=4'b0010, carry_to_alu=1.
